// File: rtl/fbuff_pkg.sv
// Shared definitions for the frame buffer arbiter slice: default RAM
// geometry and the sequencer state type.
package fbuff_pkg;

    localparam int FBUFF_WIDTH = 60;
    localparam int FBUFF_DEPTH = 3840;
    localparam int FBUFF_AW    = $clog2(FBUFF_DEPTH);

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_ARB   = 1'b1
    } fbuff_state_t;

endpackage

// File: rtl/fbuff_if.sv
// Request/response bundle between the line controller / pixel writer
// (master) and the frame buffer arbiter (slave).
interface fbuff_if
    import fbuff_pkg::*;
#(
    parameter int WIDTH = fbuff_pkg::FBUFF_WIDTH,
    parameter int AW    = fbuff_pkg::FBUFF_AW
);
    logic             clear_i;
    logic             rd_req_i;
    logic [AW-1:0]    rd_addr_i;
    logic             rd_ack_o;
    logic [WIDTH-1:0] rd_data_o;
    logic             rd_valid_o;
    logic             wr_req_i;
    logic [AW-1:0]    wr_addr_i;
    logic [WIDTH-1:0] wr_data_i;
    logic             wr_ack_o;
    logic             busy_o;
    logic             err_o;

    modport master (
        output clear_i, rd_req_i, rd_addr_i, wr_req_i, wr_addr_i, wr_data_i,
        input  rd_ack_o, rd_data_o, rd_valid_o, wr_ack_o, busy_o, err_o
    );

    modport slave (
        input  clear_i, rd_req_i, rd_addr_i, wr_req_i, wr_addr_i, wr_data_i,
        output rd_ack_o, rd_data_o, rd_valid_o, wr_ack_o, busy_o, err_o
    );
endinterface

// File: rtl/fbuff_rd_pipe.sv
// Read-return tracker: one valid bit and one in-range flag per read grant,
// delayed so they line up with the RAM's output data.
module fbuff_rd_pipe #(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic rstn,
    input  logic in_valid,
    input  logic in_range,
    output logic out_valid,
    output logic out_range
);

    logic [DEPTH-1:0] valid_r;
    logic [DEPTH-1:0] range_r;

    // Shift grant markers toward the output; reset drops reads in flight.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            valid_r <= '0;
            range_r <= '0;
        end else begin
            valid_r[0] <= in_valid;
            range_r[0] <= in_range;
            for (int i = 1; i < DEPTH; i++) begin
                valid_r[i] <= valid_r[i-1];
                range_r[i] <= range_r[i-1];
            end
        end
    end

    assign out_valid = valid_r[DEPTH-1];
    assign out_range = range_r[DEPTH-1];

endmodule

// File: rtl/fbuff_arbiter.sv
// Shares the single frame buffer RAM port between a read stream (priority)
// and a write stream (starvation-guarded), and zero-fills the buffer after
// reset or on request.
module fbuff_arbiter
    import fbuff_pkg::*;
#(
    parameter int FBUFF_WIDTH    = fbuff_pkg::FBUFF_WIDTH,
    parameter int FBUFF_DEPTH    = fbuff_pkg::FBUFF_DEPTH,
    parameter int AW             = $clog2(FBUFF_DEPTH),
    parameter int RD_LATENCY     = 1,
    parameter int MAX_RD_RUN     = 8,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                   clka,
    input  logic                   rstn,
    fbuff_if.slave                 bus,
    output logic [AW-1:0]          ram_addr_o,
    output logic [FBUFF_WIDTH-1:0] ram_din_o,
    output logic                   ram_we_o,
    output logic                   ram_en_o,
    input  logic [FBUFF_WIDTH-1:0] ram_dout_i
);

    localparam int SW = $clog2(MAX_RD_RUN + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(MAX_RD_RUN);
    localparam logic [AW-1:0] LAST_ADDR  = AW'(FBUFF_DEPTH - 1);
    localparam logic [AW:0]   DEPTH_EXT  = (AW+1)'(FBUFF_DEPTH);

    // Addresses at or past the buffer depth are acknowledged but never reach the RAM.
    function automatic logic addr_in_range(input logic [AW-1:0] addr);
        return ({1'b0, addr} < DEPTH_EXT);
    endfunction

    fbuff_state_t           state_r;
    logic [AW-1:0]          clr_addr_r;
    logic [SW-1:0]          starve_r;
    logic [AW-1:0]          ram_addr_r;
    logic [FBUFF_WIDTH-1:0] ram_din_r;
    logic                   ram_we_r;
    logic                   ram_en_r;
    logic                   err_r;
    logic                   rd_ack_s;
    logic                   wr_ack_s;
    logic                   rd_in_s;
    logic                   wr_in_s;
    logic                   pipe_valid_s;
    logic                   pipe_range_s;

    // Grant decision: reads win unless a write has waited MAX_RD_RUN reads.
    always_comb begin
        rd_in_s  = addr_in_range(bus.rd_addr_i);
        wr_in_s  = addr_in_range(bus.wr_addr_i);
        rd_ack_s = 1'b0;
        wr_ack_s = 1'b0;
        if ((state_r == ST_ARB) && !bus.clear_i) begin
            rd_ack_s = bus.rd_req_i && (!bus.wr_req_i || (starve_r < STARVE_MAX));
            wr_ack_s = bus.wr_req_i && !rd_ack_s;
        end else begin
            rd_ack_s = 1'b0;
            wr_ack_s = 1'b0;
        end
    end

    // Sequencer: clear sweep walks every address once, then arbitration resumes.
    always_ff @(posedge clka) begin
        if (!rstn) begin
            state_r    <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_ARB;
            clr_addr_r <= '0;
        end else begin
            case (state_r)
                ST_CLEAR: begin
                    if (clr_addr_r == LAST_ADDR) begin
                        state_r    <= ST_ARB;
                        clr_addr_r <= '0;
                    end else begin
                        clr_addr_r <= clr_addr_r + AW'(1);
                    end
                end
                ST_ARB: begin
                    if (bus.clear_i) begin
                        state_r    <= ST_CLEAR;
                        clr_addr_r <= '0;
                    end
                end
                default: begin
                    state_r    <= ST_ARB;
                    clr_addr_r <= '0;
                end
            endcase
        end
    end

    // Count reads granted over a waiting write; any write grant or idle write side clears it.
    always_ff @(posedge clka) begin
        if (!rstn) begin
            starve_r <= '0;
        end else if (!bus.wr_req_i || wr_ack_s) begin
            starve_r <= '0;
        end else if (rd_ack_s && (starve_r < STARVE_MAX)) begin
            starve_r <= starve_r + SW'(1);
        end
    end

    // RAM port drive and the out-of-range error pulse, all one cycle after the grant.
    always_ff @(posedge clka) begin
        if (!rstn) begin
            ram_addr_r <= '0;
            ram_din_r  <= '0;
            ram_we_r   <= 1'b0;
            ram_en_r   <= 1'b0;
            err_r      <= 1'b0;
        end else begin
            err_r <= (rd_ack_s && !rd_in_s) || (wr_ack_s && !wr_in_s);
            if (state_r == ST_CLEAR) begin
                ram_addr_r <= clr_addr_r;
                ram_din_r  <= '0;
                ram_we_r   <= 1'b1;
                ram_en_r   <= 1'b1;
            end else if (wr_ack_s && wr_in_s) begin
                ram_addr_r <= bus.wr_addr_i;
                ram_din_r  <= bus.wr_data_i;
                ram_we_r   <= 1'b1;
                ram_en_r   <= 1'b1;
            end else if (rd_ack_s && rd_in_s) begin
                ram_addr_r <= bus.rd_addr_i;
                ram_we_r   <= 1'b0;
                ram_en_r   <= 1'b1;
            end else begin
                ram_we_r   <= 1'b0;
                ram_en_r   <= 1'b0;
            end
        end
    end

    fbuff_rd_pipe #(
        .DEPTH (1 + RD_LATENCY)
    ) u_rd_pipe (
        .clk       (clka),
        .rstn      (rstn),
        .in_valid  (rd_ack_s),
        .in_range  (rd_ack_s && rd_in_s),
        .out_valid (pipe_valid_s),
        .out_range (pipe_range_s)
    );

    assign bus.rd_ack_o   = rd_ack_s;
    assign bus.wr_ack_o   = wr_ack_s;
    assign bus.rd_valid_o = pipe_valid_s;
    assign bus.rd_data_o  = pipe_range_s ? ram_dout_i : '0;
    assign bus.busy_o     = (state_r == ST_CLEAR);
    assign bus.err_o      = err_r;
    assign ram_addr_o     = ram_addr_r;
    assign ram_din_o      = ram_din_r;
    assign ram_we_o       = ram_we_r;
    assign ram_en_o       = ram_en_r;

endmodule

// File: tb/tb_fbuff_arbiter.sv
// Directed bench for fbuff_arbiter with a behavioural 1-cycle RAM behind it.
module tb_fbuff_arbiter;
    import fbuff_pkg::*;

    logic        clka = 1'b0;
    logic        rstn;
    logic [11:0] ram_addr;
    logic [59:0] ram_din;
    logic        ram_we;
    logic        ram_en;
    logic [59:0] ram_dout = 60'd0;
    logic [59:0] mem [0:3839];

    int checks = 0;
    int errors = 0;

    fbuff_if bus ();

    fbuff_arbiter dut (
        .clka       (clka),
        .rstn       (rstn),
        .bus        (bus),
        .ram_addr_o (ram_addr),
        .ram_din_o  (ram_din),
        .ram_we_o   (ram_we),
        .ram_en_o   (ram_en),
        .ram_dout_i (ram_dout)
    );

    always #5 clka = ~clka;

    // Frame buffer RAM model: single port, read data one cycle after enable.
    always @(posedge clka) begin
        if (ram_en && ram_we) mem[ram_addr] <= ram_din;
        if (ram_en && !ram_we) ram_dout <= mem[ram_addr];
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive_idle();
        bus.clear_i   = 1'b0;
        bus.rd_req_i  = 1'b0;
        bus.rd_addr_i = 12'd0;
        bus.wr_req_i  = 1'b0;
        bus.wr_addr_i = 12'd0;
        bus.wr_data_i = 60'd0;
    endtask

    // Called at posedge+1; returns at posedge+1 with requests idle.
    task automatic do_write(input logic [11:0] addr, input logic [59:0] data);
        bus.wr_req_i = 1'b1; bus.wr_addr_i = addr; bus.wr_data_i = data;
        @(negedge clka);
        check("wr_ack", {63'd0, bus.wr_ack_o}, 64'd1);
        @(posedge clka); #1;
        bus.wr_req_i = 1'b0;
        @(negedge clka);
        check("wr_ram_we", {63'd0, ram_we}, 64'd1);
        check("wr_ram_addr", {52'd0, ram_addr}, {52'd0, addr});
        @(posedge clka); #1;
    endtask

    // Single read with an empty return pipe: ack in t, enable in t+1, data in t+2.
    task automatic do_read(input logic [11:0] addr, input logic [59:0] exp, input logic oob);
        bus.rd_req_i = 1'b1; bus.rd_addr_i = addr;
        @(negedge clka);
        check("rd_ack", {63'd0, bus.rd_ack_o}, 64'd1);
        @(posedge clka); #1;
        bus.rd_req_i = 1'b0;
        @(negedge clka);
        check("rd_t1_en", {63'd0, ram_en}, {63'd0, !oob});
        check("rd_t1_err", {63'd0, bus.err_o}, {63'd0, oob});
        check("rd_t1_valid", {63'd0, bus.rd_valid_o}, 64'd0);
        @(negedge clka);
        check("rd_t2_valid", {63'd0, bus.rd_valid_o}, 64'd1);
        check("rd_t2_data", {4'd0, bus.rd_data_o}, {4'd0, exp});
        @(negedge clka);
        check("rd_t3_valid", {63'd0, bus.rd_valid_o}, 64'd0);
        @(posedge clka); #1;
    endtask

    typedef struct {
        logic        rd_req;
        logic [11:0] rd_addr;
        logic        wr_req;
        logic [11:0] wr_addr;
        logic [59:0] wr_data;
        logic        e_rd_ack;
        logic        e_wr_ack;
        logic        e_en;
        logic        e_we;
        logic [11:0] e_addr;
        logic [59:0] e_din;
        logic        e_err;
    } vec_t;

    vec_t vecs [8];

    initial begin
        int busy_cnt;
        int we_cnt;
        int bad;
        int early;
        logic got;

        vecs[0] = '{1'b0, 12'd0,    1'b1, 12'd100,  60'hABC, 1'b0, 1'b1, 1'b1, 1'b1, 12'd100, 60'hABC, 1'b0};
        vecs[1] = '{1'b0, 12'd0,    1'b1, 12'd3840, 60'h1,   1'b0, 1'b1, 1'b0, 1'b0, 12'd0,   60'h0,   1'b1};
        vecs[2] = '{1'b1, 12'd100,  1'b0, 12'd0,    60'h0,   1'b1, 1'b0, 1'b1, 1'b0, 12'd100, 60'h0,   1'b0};
        vecs[3] = '{1'b1, 12'd3840, 1'b0, 12'd0,    60'h0,   1'b1, 1'b0, 1'b0, 1'b0, 12'd0,   60'h0,   1'b1};
        vecs[4] = '{1'b0, 12'd0,    1'b0, 12'd0,    60'h0,   1'b0, 1'b0, 1'b0, 1'b0, 12'd0,   60'h0,   1'b0};
        vecs[5] = '{1'b1, 12'd5,    1'b1, 12'd6,    60'h777, 1'b1, 1'b0, 1'b1, 1'b0, 12'd5,   60'h0,   1'b0};
        vecs[6] = '{1'b0, 12'd0,    1'b1, 12'd6,    60'h123, 1'b0, 1'b1, 1'b1, 1'b1, 12'd6,   60'h123, 1'b0};
        vecs[7] = '{1'b1, 12'd4095, 1'b0, 12'd0,    60'h0,   1'b1, 1'b0, 1'b0, 1'b0, 12'd0,   60'h0,   1'b1};

        // Reset values.
        rstn = 1'b0;
        drive_idle();
        repeat (2) @(posedge clka);
        #1;
        @(negedge clka);
        check("rst_ram_en", {63'd0, ram_en}, 64'd0);
        check("rst_ram_we", {63'd0, ram_we}, 64'd0);
        check("rst_ram_addr", {52'd0, ram_addr}, 64'd0);
        check("rst_ram_din", {4'd0, ram_din}, 64'd0);
        check("rst_rd_valid", {63'd0, bus.rd_valid_o}, 64'd0);
        check("rst_rd_data", {4'd0, bus.rd_data_o}, 64'd0);
        check("rst_err", {63'd0, bus.err_o}, 64'd0);
        check("rst_busy", {63'd0, bus.busy_o}, 64'd1);

        // Sweep after reset release: 3840 zero writes at 0..3839.
        @(posedge clka); #1;
        rstn = 1'b1;
        busy_cnt = 0; we_cnt = 0; bad = 0;
        for (int cyc = 0; cyc < 5000; cyc++) begin
            @(negedge clka);
            if (bus.busy_o) busy_cnt++;
            if (bus.rd_ack_o || bus.wr_ack_o) bad++;
            if (ram_we) begin
                if (ram_addr != we_cnt[11:0] || ram_din != 60'd0 || !ram_en) bad++;
                we_cnt++;
            end
            if (!bus.busy_o && !ram_we && we_cnt > 0) break;
        end
        check("sweep_busy_cycles", 64'(busy_cnt), 64'd3840);
        check("sweep_write_count", 64'(we_cnt), 64'd3840);
        check("sweep_bad_cycles", 64'(bad), 64'd0);

        // Table-driven single-cycle grants and the RAM drive they produce.
        @(posedge clka); #1;
        foreach (vecs[i]) begin
            bus.rd_req_i  = vecs[i].rd_req;
            bus.rd_addr_i = vecs[i].rd_addr;
            bus.wr_req_i  = vecs[i].wr_req;
            bus.wr_addr_i = vecs[i].wr_addr;
            bus.wr_data_i = vecs[i].wr_data;
            @(negedge clka);
            check($sformatf("vec%0d_rd_ack", i), {63'd0, bus.rd_ack_o}, {63'd0, vecs[i].e_rd_ack});
            check($sformatf("vec%0d_wr_ack", i), {63'd0, bus.wr_ack_o}, {63'd0, vecs[i].e_wr_ack});
            @(posedge clka); #1;
            check($sformatf("vec%0d_en", i), {63'd0, ram_en}, {63'd0, vecs[i].e_en});
            check($sformatf("vec%0d_we", i), {63'd0, ram_we}, {63'd0, vecs[i].e_we});
            check($sformatf("vec%0d_err", i), {63'd0, bus.err_o}, {63'd0, vecs[i].e_err});
            if (vecs[i].e_en) check($sformatf("vec%0d_addr", i), {52'd0, ram_addr}, {52'd0, vecs[i].e_addr});
            if (vecs[i].e_we) check($sformatf("vec%0d_din", i), {4'd0, ram_din}, {4'd0, vecs[i].e_din});
        end
        drive_idle();
        repeat (3) @(posedge clka);
        #1;

        // Read-back latency, out-of-range reads and cleared contents.
        do_read(12'd100, 60'hABC, 1'b0);
        do_read(12'd3840, 60'd0, 1'b1);
        do_read(12'd6, 60'h123, 1'b0);
        do_read(12'd200, 60'd0, 1'b0);
        do_write(12'd5, 60'h5A5);
        do_read(12'd5, 60'h5A5, 1'b0);

        // Back-to-back reads return one result per cycle, in order.
        bus.rd_req_i = 1'b1; bus.rd_addr_i = 12'd100;
        @(negedge clka);
        check("b2b_ack0", {63'd0, bus.rd_ack_o}, 64'd1);
        @(posedge clka); #1;
        bus.rd_addr_i = 12'd6;
        @(negedge clka);
        check("b2b_ack1", {63'd0, bus.rd_ack_o}, 64'd1);
        @(posedge clka); #1;
        bus.rd_addr_i = 12'd5;
        @(negedge clka);
        check("b2b_valid0", {63'd0, bus.rd_valid_o}, 64'd1);
        check("b2b_data0", {4'd0, bus.rd_data_o}, 64'hABC);
        @(posedge clka); #1;
        bus.rd_req_i = 1'b0;
        @(negedge clka);
        check("b2b_data1", {3'd0, bus.rd_valid_o, bus.rd_data_o}, {4'd1, 60'h123});
        @(negedge clka);
        check("b2b_data2", {3'd0, bus.rd_valid_o, bus.rd_data_o}, {4'd1, 60'h5A5});
        @(posedge clka); #1;

        // Both requesters held: 8 reads then 1 write, repeating.
        bus.rd_req_i = 1'b1; bus.rd_addr_i = 12'd10;
        bus.wr_req_i = 1'b1; bus.wr_addr_i = 12'd11; bus.wr_data_i = 60'h99;
        for (int i = 0; i < 27; i++) begin
            @(negedge clka);
            check($sformatf("starve_cyc%0d", i), {62'd0, bus.rd_ack_o, bus.wr_ack_o},
                  ((i % 9) == 8) ? 64'd1 : 64'd2);
            @(posedge clka); #1;
        end
        drive_idle();
        repeat (3) @(posedge clka);
        #1;

        // Clear with a simultaneous write, plus a second clear mid-sweep.
        bus.clear_i = 1'b1;
        bus.wr_req_i = 1'b1; bus.wr_addr_i = 12'd7; bus.wr_data_i = 60'h77;
        @(negedge clka);
        check("clr_cycle_wr_ack", {63'd0, bus.wr_ack_o}, 64'd0);
        check("clr_cycle_busy", {63'd0, bus.busy_o}, 64'd0);
        @(posedge clka); #1;
        bus.clear_i = 1'b0;
        busy_cnt = 0; early = 0; got = 1'b0;
        for (int k = 1; k < 5000; k++) begin
            @(negedge clka);
            if (k == 100) bus.clear_i = 1'b1;
            if (k == 101) bus.clear_i = 1'b0;
            if (bus.busy_o) begin
                busy_cnt++;
                if (bus.wr_ack_o) early++;
            end else begin
                check("clr_first_arb_wr_ack", {63'd0, bus.wr_ack_o}, 64'd1);
                got = 1'b1;
                break;
            end
        end
        check("clr_busy_cycles", 64'(busy_cnt), 64'd3840);
        check("clr_ack_during_busy", 64'(early), 64'd0);
        check("clr_sweep_ended", {63'd0, got}, 64'd1);
        @(posedge clka); #1;
        drive_idle();
        @(negedge clka);
        check("clr_write_drive", {50'd0, ram_we, ram_en, ram_addr}, {50'd0, 1'b1, 1'b1, 12'd7});

        // Reset pulse in the middle of back-to-back reads.
        @(posedge clka); #1;
        bus.rd_req_i = 1'b1; bus.rd_addr_i = 12'd100;
        @(negedge clka);
        check("rstmid_ack0", {63'd0, bus.rd_ack_o}, 64'd1);
        @(posedge clka); #1;
        bus.rd_addr_i = 12'd6;
        rstn = 1'b0;
        @(negedge clka);
        check("rstmid_ack1", {63'd0, bus.rd_ack_o}, 64'd1);
        @(posedge clka); #1;
        rstn = 1'b1;
        bus.rd_req_i = 1'b0;
        @(negedge clka);
        check("rstmid_valid_t2", {63'd0, bus.rd_valid_o}, 64'd0);
        check("rstmid_data", {4'd0, bus.rd_data_o}, 64'd0);
        check("rstmid_ram", {50'd0, ram_en, ram_we, ram_addr}, 64'd0);
        check("rstmid_din", {4'd0, ram_din}, 64'd0);
        check("rstmid_err_busy", {62'd0, bus.err_o, bus.busy_o}, 64'd1);
        @(negedge clka);
        check("rstmid_valid_t3", {63'd0, bus.rd_valid_o}, 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
